// File: rtl/data_ram_pkg.sv
// Shared codes, FSM states and byte-lane helpers for the data RAM responder.
package data_ram_pkg;

   localparam int NUM_LANES = 4;

   localparam logic [1:0] RW_IDLE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b10;
   localparam logic [1:0] RW_WRITE = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_e;

   typedef struct packed {
      logic        write;
      logic        bad;
      logic [1:0]  size;
      logic [1:0]  off;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [NUM_LANES-1:0] size_to_be(input logic [1:0] off,
                                                      input logic [1:0] size);
      logic [NUM_LANES-1:0] m;
      case (size)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m << off;
   endfunction

   function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
      return ({1'b0, off} + {1'b0, size}) > 3'd3;
   endfunction

   function automatic logic [31:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 32'h0000_00FF;
         2'd1:    return 32'h0000_FFFF;
         2'd2:    return 32'h00FF_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/data_ram_bank.sv
// Byte-lane synchronous SRAM, one read/write port; contents are never reset.
module data_ram_bank
   import data_ram_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic                          clk,
   input  logic                          en,
   input  logic                          we,
   input  logic [NUM_LANES-1:0]          be,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [NUM_LANES-1:0][7:0]     wdata,
   output logic [NUM_LANES-1:0][7:0]     rdata
);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [7:0] mem [2**ADDR_W];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (en && we && be[l]) mem[addr] <= wdata[l];
         if (en && !we)         rd_q      <= mem[addr];
      end

      assign rdata[l] = rd_q;
   end

endmodule

// File: rtl/data_ram_responder.sv
// Bus responder: IDLE -> WAIT (WAIT_CYC) -> ACCESS -> DONE over a byte-lane RAM.
// Optional range check on upper address bits: DATA_RAM_RESPONDER_BOUNDS_CHECK_EN.
module data_ram_responder
   import data_ram_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int WAIT_CYC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   inout  wire  [31:0] data_bus,
   input  logic [31:0] data_address,
   input  logic [1:0]  data_rw,
   input  logic [1:0]  data_size,
   output logic        data_rw_cplt,
   output logic        busy,
   output logic        err,
   output logic [7:0]  err_cnt
);

   state_e              state_q, state_d;
   req_t                req_q, req_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                range_err;
   logic                unused_hi;
   logic [31:0]         rd_word, rd_shift, rd_fmt;

   assign unused_hi = ^data_address[31:ADDR_W+2];

`ifdef DATA_RAM_RESPONDER_BOUNDS_CHECK_EN
   assign range_err = |data_address[31:ADDR_W+2];
`else
   assign range_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      widx_d    = widx_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (data_rw[1]) begin
               req_d.write = data_rw[0];
               req_d.size  = data_size;
               req_d.off   = data_address[1:0];
               req_d.bad   = crosses(data_address[1:0], data_size) | range_err;
               req_d.wdata = data_bus;
               widx_d      = data_address[ADDR_W+1:2];
               if (WAIT_CYC > 0) begin
                  cnt_d   = 4'(WAIT_CYC);
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_ACCESS;
         end
         ST_ACCESS: state_d = ST_DONE;
         ST_DONE: begin
            state_d = ST_IDLE;
            if (req_q.bad && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         widx_q    <= '0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         widx_q    <= widx_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // A faulted transaction never enables the RAM, so a bad write leaves memory intact.
   data_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .en    (state_q == ST_ACCESS && !req_q.bad),
      .we    (req_q.write),
      .be    (size_to_be(req_q.off, req_q.size)),
      .addr  (widx_q),
      .wdata (req_q.wdata << {req_q.off, 3'b000}),
      .rdata (rd_word)
   );

   assign rd_shift = rd_word >> {req_q.off, 3'b000};
   assign rd_fmt   = req_q.bad ? 32'h0 : (rd_shift & size_mask(req_q.size));

   assign data_bus     = (state_q == ST_DONE && !req_q.write) ? rd_fmt : 'z;
   assign data_rw_cplt = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE);
   assign err          = (state_q == ST_DONE) && req_q.bad;
   assign err_cnt      = err_cnt_q;

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-address width (memory = 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 1, legal 0..15, meaning wait states inserted before the memory access.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port data_bus, inout, 32, meaning shared read/write data bus.
REQ-006 SHALL have port data_address, input, 32, meaning byte address.
REQ-007 SHALL have port data_rw, input, 2, meaning 0/1 idle, 2 read, 3 write.
REQ-008 SHALL have port data_size, input, 2, meaning transfer of data_size+1 bytes.
REQ-009 SHALL have port data_rw_cplt, output, 1, meaning one-cycle completion strobe.
REQ-010 SHALL have port busy, output, 1, meaning a transaction is in flight (any state except IDLE).
REQ-011 SHALL have port err, output, 1, meaning one-cycle error flag, coincident with data_rw_cplt.
REQ-012 SHALL have port err_cnt, output, 8, meaning saturating error count.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, ACCESS, DONE.
REQ-014 In IDLE with data_rw[1]=1, SHALL capture address, size, direction and (for write) data_bus at posedge, then go to WAIT if WAIT_CYC>0, else ACCESS.
REQ-015 WAIT SHALL last exactly WAIT_CYC cycles, using a 4-bit down-counter, then go to ACCESS.
REQ-016 ACCESS SHALL perform the memory operation in one cycle, then go to DONE.
REQ-017 DONE SHALL assert data_rw_cplt for exactly one cycle, then return to IDLE; the CPU SHALL have advanced its request by the next cycle, and the request is re-sampled there (back-to-back, no bubble).
REQ-018 Latency: data_rw_cplt SHALL be high in cycle WAIT_CYC+2 counted from the accepting edge (cycle 0).
REQ-019 Read SHALL return bytes addr..addr+size little-endian, right-justified and zero-extended on data_bus.
REQ-020 data_bus SHALL be driven only in DONE of a read; it is high-Z otherwise.
REQ-021 Write SHALL store the low size+1 captured bytes to addr..addr+size via byte enables; other bytes stay unchanged.
REQ-022 Misalignment: if address[1:0]+size > 3 (word crossing), SHALL write nothing, return 0 on read, and pulse err with data_rw_cplt.
REQ-023 Changes to data_rw, data_address or data_size after acceptance SHALL be ignored; the captured transaction completes.
REQ-024 err_cnt SHALL increment on every err pulse and saturate at 255.

Reset
REQ-025 rst_n low SHALL force IDLE, data_rw_cplt=0, busy=0, err=0, err_cnt=0, data_bus high-Z, and the wait counter to 0.
REQ-026 Reset asserted in WAIT SHALL drop the write uncommitted; reset in the ACCESS cycle leaves the written word undefined; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With DATA_RAM_RESPONDER_BOUNDS_CHECK_EN defined, any data_address[31:ADDR_W+2] nonzero SHALL be treated as an error per REQ-022.
REQ-028 Without DATA_RAM_RESPONDER_BOUNDS_CHECK_EN, upper address bits SHALL be ignored (the address wraps modulo memory size) and no range error is raised.

Structure
REQ-029 Package data_ram_pkg SHALL hold the RW_IDLE/RW_READ/RW_WRITE codes, the FSM state enum, and the size-to-byte-enable and crossing-check functions.
REQ-030 Sub-module data_ram_bank SHALL hold the 4-lane byte-enable synchronous SRAM (one read/write port); the FSM, capture, bus drive and error logic stay in data_ram_responder.

Verification
REQ-031 Bench: WAIT_CYC=1; write rw=3, size=3, addr 0x10, data 0xDEADBEEF, then read size=3 -> data_rw_cplt in cycle 3 each; read returns 0xDEADBEEF.
REQ-032 Bench: after REQ-031, write size=0 at addr 0x12, data 0x55; read size=3 at 0x10 -> 0xDE55BEEF; read size=1 at 0x12 -> 0x0000DE55.
REQ-033 Bench: write size=1 at addr 0x13 -> err=1 with cplt, word unchanged, err_cnt=1; then read size=3 at 0x11 -> 0x00000000, err_cnt=2.
REQ-034 Bench: WAIT_CYC=0; back-to-back reads at 0x10 and 0x14 -> cplt in cycles 2 and 5; busy low only in the IDLE cycle between them.
REQ-035 Bench: assert rst_n low during WAIT of a write to 0x20 -> cplt never pulses; subsequent read of 0x20 returns the prior value; err_cnt=0.
REQ-036 Bench: read at 0x4000_0010 -> returns the contents of 0x10 without the macro; returns 0 with err=1 with DATA_RAM_RESPONDER_BOUNDS_CHECK_EN.
